// File: rtl/hsci_master_regfile.sv
// Multi-channel HSCI master control/status register file: per-channel run/soft-reset
// pulses, sticky W1C flags with IRQ masking, and a clear-on-read done counter.

module hsci_master_regfile_ch (
  input  logic        clk,
  input  logic        srstn,
  input  logic        en_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_stat_i,
  input  logic        wr_mask_i,
  input  logic [15:0] wdata_i,
  input  logic        rd_clr_i,
  input  logic        busy_i,
  input  logic        done_i,
  input  logic        err_i,
  output logic        run_o,
  output logic        sreset_o,
  output logic [7:0]  mode_o,
  output logic [2:0]  flags_o,
  output logic [2:0]  mask_o,
  output logic [15:0] cnt_o,
  output logic        pend_o
);

  logic        run_q, run_d;
  logic        srst_q, srst_d;
  logic [7:0]  mode_q, mode_d;
  logic [2:0]  flags_q, flags_d;
  logic [2:0]  mask_q, mask_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  hw_set, w1c;
  logic        done_ev;
  logic        unused_w;

  assign unused_w = ^wdata_i[7:4];

  always_comb begin
    run_d   = wr_ctrl_i & wdata_i[0] & ~busy_i;
    srst_d  = wr_ctrl_i & wdata_i[1];
    done_ev = en_i & done_i;
    // flags_q[0]=DONE, [1]=ERR, [2]=RUN_REJ (STATUS bits 1..3)
    hw_set  = {wr_ctrl_i & wdata_i[0] & busy_i, en_i & err_i, done_ev};
    w1c     = wr_stat_i ? wdata_i[3:1] : 3'b000;
    mode_d  = wr_ctrl_i ? wdata_i[15:8] : mode_q;
    mask_d  = wr_mask_i ? wdata_i[3:1] : mask_q;
    // soft reset beats hardware set, which beats W1C
    flags_d = srst_d ? 3'b000 : (hw_set | (flags_q & ~w1c));
    cnt_d   = cnt_q;
    if (srst_d)
      cnt_d = '0;
    else if (rd_clr_i)
      cnt_d = {15'd0, done_ev};
    else if (done_ev && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      run_q   <= 1'b0;
      srst_q  <= 1'b0;
      mode_q  <= '0;
      flags_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      run_q   <= run_d;
      srst_q  <= srst_d;
      mode_q  <= mode_d;
      flags_q <= flags_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run_o    = run_q;
  assign sreset_o = srst_q;
  assign mode_o   = mode_q;
  assign flags_o  = flags_q;
  assign mask_o   = mask_q;
  assign cnt_o    = cnt_q;
  assign pend_o   = |(flags_q & mask_q);

endmodule

module hsci_master_regfile #(
  parameter int          NUM_CH     = 4,
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] VERSION    = 32'h0002_0000
) (
  input  logic                    clk,
  input  logic                    srstn,
  input  logic                    I_wr_stb,
  input  logic [ADDR_WIDTH-1:0]   I_wr_addr,
  input  logic [DATA_WIDTH-1:0]   I_wr_data,
  input  logic                    I_rd_stb,
  input  logic [ADDR_WIDTH-1:0]   I_rd_addr,
  output logic [DATA_WIDTH-1:0]   O_read_data,
  output logic [NUM_CH-1:0]       ch_run_o,
  output logic [NUM_CH-1:0]       ch_sreset_o,
  output logic [8*NUM_CH-1:0]     ch_mode_o,
  input  logic [NUM_CH-1:0]       ch_busy_i,
  input  logic [NUM_CH-1:0]       ch_done_i,
  input  logic [NUM_CH-1:0]       ch_err_i,
  output logic                    irq_o
);

  localparam logic [ADDR_WIDTH-1:0] G_ADDR = ADDR_WIDTH'(4 * NUM_CH);

  logic                        en_q;
  logic [DATA_WIDTH-1:0]       rd_q, rd_d;
  logic                        irq_q;
  logic [NUM_CH-1:0][7:0]      mode_w;
  logic [NUM_CH-1:0][2:0]      flags_w, mask_w;
  logic [NUM_CH-1:0][15:0]     cnt_w;
  logic [NUM_CH-1:0]           pend_w;
  logic                        unused_wr;

  assign unused_wr = ^I_wr_data[DATA_WIDTH-1:16];

  // Released reset reaches the register logic one edge later, so the first
  // accepted write/event lands on the second edge after deassertion.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) en_q <= 1'b0;
    else        en_q <= 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(4 * c);
    logic wr_hit;
    assign wr_hit = en_q & I_wr_stb;

    hsci_master_regfile_ch u_ch (
      .clk       (clk),
      .srstn     (srstn),
      .en_i      (en_q),
      .wr_ctrl_i (wr_hit & (I_wr_addr == BASE)),
      .wr_stat_i (wr_hit & (I_wr_addr == (BASE + ADDR_WIDTH'(1)))),
      .wr_mask_i (wr_hit & (I_wr_addr == (BASE + ADDR_WIDTH'(2)))),
      .wdata_i   (I_wr_data[15:0]),
      .rd_clr_i  (en_q & I_rd_stb & (I_rd_addr == (BASE + ADDR_WIDTH'(3)))),
      .busy_i    (ch_busy_i[c]),
      .done_i    (ch_done_i[c]),
      .err_i     (ch_err_i[c]),
      .run_o     (ch_run_o[c]),
      .sreset_o  (ch_sreset_o[c]),
      .mode_o    (mode_w[c]),
      .flags_o   (flags_w[c]),
      .mask_o    (mask_w[c]),
      .cnt_o     (cnt_w[c]),
      .pend_o    (pend_w[c])
    );
  end

  assign ch_mode_o = mode_w;

  always_comb begin
    rd_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (I_rd_addr == ADDR_WIDTH'(4 * c))     rd_d[15:8] = mode_w[c];
      if (I_rd_addr == ADDR_WIDTH'(4 * c + 1)) rd_d[3:0]  = {flags_w[c], ch_busy_i[c]};
      if (I_rd_addr == ADDR_WIDTH'(4 * c + 2)) rd_d[3:1]  = mask_w[c];
      if (I_rd_addr == ADDR_WIDTH'(4 * c + 3)) rd_d[15:0] = cnt_w[c];
    end
    if (I_rd_addr == G_ADDR)                    rd_d[31:0]       = VERSION;
    if (I_rd_addr == G_ADDR + ADDR_WIDTH'(1))   rd_d[NUM_CH-1:0] = pend_w;
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      rd_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      if (I_rd_stb) rd_q <= rd_d;
      irq_q <= |pend_w;
    end
  end

  assign O_read_data = rd_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_hsci_master_regfile.sv
// Directed bench for hsci_master_regfile (NUM_CH=4): table-driven register
// vectors plus hand sequences for pulses, W1C priority, saturation and reset.

module tb_hsci_master_regfile;
  localparam int          NCH = 4;
  localparam int          AW  = 10;
  localparam int          DW  = 32;
  localparam logic [31:0] VER = 32'h0002_0000;

  logic            clk = 1'b0;
  logic            srstn = 1'b0;
  logic            I_wr_stb = 1'b0;
  logic [AW-1:0]   I_wr_addr = '0;
  logic [DW-1:0]   I_wr_data = '0;
  logic            I_rd_stb = 1'b0;
  logic [AW-1:0]   I_rd_addr = '0;
  logic [DW-1:0]   O_read_data;
  logic [NCH-1:0]  ch_run_o, ch_sreset_o;
  logic [8*NCH-1:0] ch_mode_o;
  logic [NCH-1:0]  ch_busy_i = '0, ch_done_i = '0, ch_err_i = '0;
  logic            irq_o;

  hsci_master_regfile #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VERSION(VER)) dut (
    .clk(clk), .srstn(srstn),
    .I_wr_stb(I_wr_stb), .I_wr_addr(I_wr_addr), .I_wr_data(I_wr_data),
    .I_rd_stb(I_rd_stb), .I_rd_addr(I_rd_addr), .O_read_data(O_read_data),
    .ch_run_o(ch_run_o), .ch_sreset_o(ch_sreset_o), .ch_mode_o(ch_mode_o),
    .ch_busy_i(ch_busy_i), .ch_done_i(ch_done_i), .ch_err_i(ch_err_i),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [31:0] exp; } rvec_t;
  typedef struct { logic [AW-1:0] waddr; logic [31:0] wdata; logic [AW-1:0] raddr; logic [31:0] exp; } wvec_t;

  rvec_t rtab[20];
  wvec_t wtab[8];
  int    n_chk = 0;
  int    n_pass = 0;
  logic [31:0] rdat;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    I_wr_stb = 1'b1; I_wr_addr = a; I_wr_data = d;
    tick();
    I_wr_stb = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    I_rd_stb = 1'b1; I_rd_addr = a;
    tick();
    d = O_read_data;
    I_rd_stb = 1'b0;
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_rdata"}, O_read_data, 32'h0);
    check({tag, "_run"}, 32'(ch_run_o), 32'h0);
    check({tag, "_sreset"}, 32'(ch_sreset_o), 32'h0);
    check({tag, "_mode"}, ch_mode_o, 32'h0);
    check({tag, "_irq"}, 32'(irq_o), 32'h0);
  endtask

  task automatic run_rtab(input string tag);
    for (int i = 0; i < 20; i++) begin
      rd(rtab[i].addr, rdat);
      check($sformatf("%s_rd%0d", tag, rtab[i].addr), rdat, rtab[i].exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 18; i++) rtab[i] = '{AW'(i), (i == 16) ? VER : 32'h0};
    rtab[18] = '{10'd18, 32'h0};
    rtab[19] = '{10'd1023, 32'h0};
    wtab[0] = '{10'd0,  32'h0000_FF00, 10'd0,  32'h0000_FF00};
    wtab[1] = '{10'd0,  32'hFFFF_FFFC, 10'd0,  32'h0000_FF00};
    wtab[2] = '{10'd6,  32'hFFFF_FFFF, 10'd6,  32'h0000_000E};
    wtab[3] = '{10'd6,  32'h0000_0004, 10'd6,  32'h0000_0004};
    wtab[4] = '{10'd6,  32'h0000_0000, 10'd2,  32'h0000_0000};
    wtab[5] = '{10'd16, 32'h0000_0000, 10'd16, VER};
    wtab[6] = '{10'd18, 32'hFFFF_FFFF, 10'd18, 32'h0000_0000};
    wtab[7] = '{10'd0,  32'h0000_0000, 10'd0,  32'h0000_0000};

    // reset state
    repeat (2) tick();
    check_outs_zero("rst");
    srstn = 1'b1;
    repeat (2) tick();
    run_rtab("rst");
    check("rst_irq_after", 32'(irq_o), 32'h0);

    for (int i = 0; i < 8; i++) begin
      wr(wtab[i].waddr, wtab[i].wdata);
      rd(wtab[i].raddr, rdat);
      check($sformatf("wvec%0d", i), rdat, wtab[i].exp);
    end

    // channel 2 run pulse + mode
    wr(10'd8, 32'h0000_5A01);
    check("ch2_run_hi", 32'(ch_run_o), 32'h4);
    check("ch2_mode", 32'(ch_mode_o[23:16]), 32'h5A);
    tick();
    check("ch2_run_lo", 32'(ch_run_o), 32'h0);
    rd(10'd8, rdat);  check("ch2_ctrl_rb", rdat, 32'h0000_5A00);
    rd(10'd9, rdat);  check("ch2_status", rdat, 32'h0);

    // rejected run on channel 1, irq via RUN_REJ mask
    ch_busy_i = 4'b0010;
    wr(10'd4, 32'h1);
    check("ch1_rej_nopulse", 32'(ch_run_o), 32'h0);
    rd(10'd5, rdat);  check("ch1_status_rej", rdat, 32'h9);
    ch_busy_i = 4'b0000;
    wr(10'd6, 32'h8);
    check("ch1_irq_pre", 32'(irq_o), 32'h0);
    tick();
    check("ch1_irq_rise", 32'(irq_o), 32'h1);
    rd(10'd17, rdat); check("irq_pend", rdat, 32'h2);
    wr(10'd5, 32'h8);
    check("ch1_irq_hold", 32'(irq_o), 32'h1);
    tick();
    check("ch1_irq_fall", 32'(irq_o), 32'h0);
    rd(10'd5, rdat);  check("ch1_status_clr", rdat, 32'h0);
    wr(10'd6, 32'h0);

    // channel 0 err: irq timing and hw-set beats W1C
    wr(10'd2, 32'h4);
    ch_err_i = 4'b0001;
    tick();
    ch_err_i = 4'b0000;
    check("ch0_err_irq_pre", 32'(irq_o), 32'h0);
    tick();
    check("ch0_err_irq_rise", 32'(irq_o), 32'h1);
    ch_err_i = 4'b0001;
    wr(10'd1, 32'h4);
    ch_err_i = 4'b0000;
    rd(10'd1, rdat);  check("ch0_err_vs_w1c", rdat, 32'h4);
    wr(10'd1, 32'h4);
    rd(10'd1, rdat);  check("ch0_err_w1c", rdat, 32'h0);
    check("ch0_irq_fall", 32'(irq_o), 32'h0);
    wr(10'd2, 32'h0);
    ch_done_i = 4'b0001;
    tick();
    ch_done_i = 4'b0000;
    rd(10'd1, rdat);  check("ch0_done_flag", rdat, 32'h2);
    rd(10'd3, rdat);  check("ch0_cnt1", rdat, 32'h1);
    rd(10'd3, rdat);  check("ch0_cnt_cor", rdat, 32'h0);
    wr(10'd1, 32'h2);

    // back-to-back runs on channel 3
    wr(10'd12, 32'h1);
    check("b2b_run1", 32'(ch_run_o), 32'h8);
    ch_busy_i = 4'b1000;
    wr(10'd12, 32'h1);
    check("b2b_run2_rej", 32'(ch_run_o), 32'h0);
    ch_busy_i = 4'b0000;
    rd(10'd13, rdat); check("b2b_rej_flag", rdat, 32'h8);
    wr(10'd13, 32'h8);
    wr(10'd12, 32'h1);
    check("b2b_ok1", 32'(ch_run_o), 32'h8);
    wr(10'd12, 32'h1);
    check("b2b_ok2", 32'(ch_run_o), 32'h8);
    tick();
    check("b2b_end", 32'(ch_run_o), 32'h0);

    // soft reset on channel 3, coinciding with a done event
    wr(10'd12, 32'h0000_1100);
    ch_done_i = 4'b1000;
    repeat (3) tick();
    ch_done_i = 4'b0000;
    rd(10'd13, rdat); check("sr_pre_status", rdat, 32'h2);
    ch_done_i = 4'b1000;
    wr(10'd12, 32'h0000_1102);
    ch_done_i = 4'b0000;
    check("sr_pulse", 32'(ch_sreset_o), 32'h8);
    check("sr_no_run", 32'(ch_run_o), 32'h0);
    tick();
    check("sr_pulse_end", 32'(ch_sreset_o), 32'h0);
    rd(10'd13, rdat); check("sr_status", rdat, 32'h0);
    rd(10'd15, rdat); check("sr_cnt", rdat, 32'h0);
    check("sr_mode_kept", 32'(ch_mode_o[31:24]), 32'h11);

    // done counter saturation and clear-on-read
    ch_done_i = 4'b1000;
    repeat (70000) tick();
    ch_done_i = 4'b0000;
    rd(10'd15, rdat); check("cnt_sat", rdat, 32'h0000_FFFF);
    rd(10'd15, rdat); check("cnt_cleared", rdat, 32'h0);
    ch_done_i = 4'b1000;
    repeat (2) tick();
    rd(10'd15, rdat); check("cnt_read_with_inc", rdat, 32'h2);
    ch_done_i = 4'b0000;
    rd(10'd15, rdat); check("cnt_inc_after_clr", rdat, 32'h1);
    wr(10'd13, 32'hE);

    // asynchronous reset mid-operation
    wr(10'd8, 32'h0000_3300);
    wr(10'd10, 32'h2);
    ch_done_i = 4'b0100;
    tick();
    ch_done_i = 4'b0000;
    tick();
    check("mid_irq_set", 32'(irq_o), 32'h1);
    rd(10'd16, rdat);
    wr(10'd8, 32'h0000_3301);
    check("mid_run_hi", 32'(ch_run_o), 32'h4);
    #2 srstn = 1'b0;
    #1;
    check_outs_zero("mid");
    @(posedge clk);
    #1 srstn = 1'b1;
    repeat (2) tick();
    run_rtab("post");
    check("post_mode", ch_mode_o, 32'h0);
    check("post_irq", 32'(irq_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hsci_master_regfile.md
# hsci_master_regfile

Parametrised multi-channel control/status register file for the HSCI master: the next-generation replacement for the single-channel register wrapper. Provides NUM_CH independent channel register sets behind the existing strobe-style register bus. Each set has a self-clearing run pulse, a soft-reset pulse, sticky W1C event flags with per-channel interrupt masking, and a clear-on-read done-event counter. It sits between the AXI register bridge and the per-lane HSCI engines.

## Interface
- NUM_CH, 4: number of channels, 1..16.
- ADDR_WIDTH, 10: word address width; must satisfy 2^ADDR_WIDTH ≥ 4·NUM_CH+2.
- DATA_WIDTH, 32: register data width; must be ≥ 32.
- VERSION, 32'h0002_0000: value of the read-only VERSION register.

Ports:
- clk  in  1  register clock; all logic on its rising edge.
- srstn  in  1  reset; asynchronous assert, active-low.
- I_wr_stb  in  1  write strobe, one cycle per write.
- I_wr_addr  in  ADDR_WIDTH  write word address.
- I_wr_data  in  DATA_WIDTH  write data.
- I_rd_stb  in  1  read strobe; qualifies clear-on-read side effects.
- I_rd_addr  in  ADDR_WIDTH  read word address.
- O_read_data  out  DATA_WIDTH  registered read data.
- ch_run_o  out  NUM_CH  per-channel run pulse.
- ch_sreset_o  out  NUM_CH  per-channel soft-reset pulse.
- ch_mode_o  out  8·NUM_CH  per-channel mode field; channel c is at [8c+7:8c].
- ch_busy_i  in  NUM_CH  channel engine busy level.
- ch_done_i  in  NUM_CH  single-cycle done event.
- ch_err_i  in  NUM_CH  single-cycle error event.
- irq_o  out  1  registered, level interrupt.

## Operation
- Address map. Channel c occupies base 4c. Global registers are at G = 4·NUM_CH.
  - 4c+0 CTRL: bit0 RUN (write-1 pulse, reads 0); bit1 SRESET (write-1 pulse, reads 0); bits[15:8] MODE (R/W).
  - 4c+1 STATUS: bit0 BUSY (RO, live ch_busy_i); bit1 DONE (W1C); bit2 ERR (W1C); bit3 RUN_REJ (W1C).
  - 4c+2 IRQ_MASK: bits[3:1] enable the matching STATUS bits; R/W; other bits read 0.
  - 4c+3 DONE_CNT: bits[15:0], saturating count of ch_done_i events; cleared by a read with I_rd_stb=1.
  - G+0 VERSION (RO).
  - G+1 IRQ_PEND (RO): bit c = OR of (STATUS[3:1] & IRQ_MASK[3:1]) for channel c.
  - Unmapped addresses read 0; writes to them are ignored.
- RUN write behaviour:
  - If ch_busy_i[c]=0 in the write cycle, ch_run_o[c] is high for exactly one cycle.
  - If ch_busy_i[c]=1, no pulse is issued and RUN_REJ is set.
- SRESET write: ch_sreset_o[c] is high for one cycle. The pulse also clears STATUS[3:1] and DONE_CNT for channel c. MODE and IRQ_MASK are unaffected.
- Flag update priority: a hardware set (ch_done_i, ch_err_i, or a rejected run) wins over a W1C in the same cycle, so the flag stays 1. SRESET wins over a hardware set in the same cycle.
- DONE_CNT:
  - Saturates at 16'hFFFF.
  - An increment in the same cycle as a clear-on-read gives 1.
  - The read returns the pre-clear value.
- irq_o is the registered OR of all IRQ_PEND bits.
- A single write updates only the addressed register. Reads have no side effects except on DONE_CNT.

## Timing
- Reset (asynchronous, srstn=0):
  - Outputs: O_read_data=0, ch_run_o=0, ch_sreset_o=0, ch_mode_o=0, irq_o=0.
  - Registers: all STATUS flags, IRQ_MASK and DONE_CNT are 0.
- Reset release is synchronised to clk. The first write is accepted on the second clk edge after deassertion.
- Read latency is 1 cycle. O_read_data reflects I_rd_addr from the previous cycle and holds until the next read.
- Write at edge N: the register is updated at N. ch_run_o and ch_sreset_o are high during cycle N+1 only.
- Event input high at edge N: the flag is set at N. IRQ_PEND shows it at N, and irq_o rises at N+1.
- W1C at edge N clears the flag at N. irq_o falls at N+1 if no other source is pending.
- Back-to-back RUN writes on consecutive cycles give two separate one-cycle pulses. Each is individually checked against ch_busy_i.
- Reset asserted mid-pulse forces the pulse low immediately.

## Test plan
- Reset, then read every mapped address -> VERSION=32'h0002_0000 and all other registers 0. irq_o=0 and all outputs 0.
- NUM_CH=4: write CTRL of channel 2 (addr 8) = 32'h0000_5A01 with busy=0 -> ch_run_o=4'b0100 for exactly 1 cycle and ch_mode_o[23:16]=8'h5A. Read back of addr 8 gives 32'h0000_5A00.
- Run write to channel 1 with ch_busy_i[1]=1 -> no ch_run_o pulse and STATUS(addr 5)=4'b1001. With IRQ_MASK(addr 6)=4'b1000, irq_o=1 one cycle later. Write 4'b1000 to addr 5 -> irq_o=0 one cycle after.
- ch_err_i[0] pulse in the same cycle as a W1C of ERR -> STATUS bit2 remains 1.
- 70000 ch_done_i pulses on channel 3 -> DONE_CNT (addr 15) reads 16'hFFFF, and the next read gives 0. A done pulse coinciding with the read gives 1 on the following read.
- Assert srstn mid-operation with pending IRQ and MODE=8'h33 -> all outputs 0 asynchronously. After release, registers read reset values.
